boot_rom_banked: RTL

Parametrised boot ROM controller: accepts pipelined reads from the core/debug fabric over a req/gnt/rvalid port, decodes them across NUM_BANKS boot-code macro instances and returns data after a fixed, configurable latency. It replaces the single-macro, enable-only wrapper with bank decoding, error responses, configurable output pipelining and optional access counters. It sits between the instruction-side interconnect and the boot-code macros.

---
 rtl/boot_rom_pkg.sv | 24 ++
 rtl/boot_rom_bank.sv | 35 +++
 rtl/boot_rom_banked.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/boot_rom_pkg.sv
// rtl/boot_rom_pkg.sv - shared widths, response-pipeline struct and boot-code contents for boot_rom_banked
package boot_rom_pkg;

  localparam int unsigned MAX_BANKS  = 8;
  localparam int unsigned BANK_IDX_W = $clog2(MAX_BANKS);

  function automatic int unsigned word_addr_w(int unsigned addr_width, int unsigned data_width);
    return addr_width - $clog2(data_width / 8);
  endfunction

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [BANK_IDX_W-1:0] bank;
  } resp_t;

  // Boot image pattern held by each macro: tag, bank index, in-bank word address.
  function automatic logic [63:0] rom_word(int unsigned bank, int unsigned addr);
    logic [31:0] w;
    w = 32'hB000_0000 | (32'(bank) << 16) | (32'(addr) & 32'h0000_FFFF);
    return {~w, w};
  endfunction

endpackage

// File: rtl/boot_rom_bank.sv
// rtl/boot_rom_bank.sv - one boot-code macro (CLK, RSTN, CSN, A, Q) with active-low chip select
module boot_rom_bank
  import boot_rom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AW         = 10,
  parameter int unsigned BANK_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_i,
  input  logic [AW-1:0]         addr_i,
  output logic                  csn_o,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic                  csn;
  logic [63:0]           word;
  logic [DATA_WIDTH-1:0] q_q;

  assign csn   = ~cs_i;
  assign csn_o = csn;
  assign word  = rom_word(BANK_ID, 32'(addr_i));
  assign q_o   = q_q;

  // Q holds its last value while deselected, like the hard macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (!csn) begin
      q_q <= word[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/boot_rom_banked.sv
// rtl/boot_rom_banked.sv - banked boot ROM with fixed-latency responses; BOOT_ROM_PERF_CNT_EN adds access counters
module boot_rom_banked
  import boot_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned BANK_WORDS  = 1024,
  parameter int unsigned PIPE_STAGES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
`ifdef BOOT_ROM_PERF_CNT_EN
  ,output logic [31:0]          acc_cnt_o
  ,output logic [15:0]          err_cnt_o
`endif
);

  localparam int unsigned BYTE_OFF = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WORD_W   = word_addr_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned IN_W     = $clog2(BANK_WORDS);

  logic [WORD_W-1:0]     word_idx;
  logic [WORD_W-1:0]     bank_full;
  logic [BANK_IDX_W-1:0] bank_sel;
  logic                  out_range;
  logic                  access;
  logic                  read_ok;
  logic [NUM_BANKS-1:0]  bank_csn;
  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];
  resp_t                 resp0_d, resp0_q, out_resp;
  logic [DATA_WIDTH-1:0] mux_data, s0_data, out_data;

  // gnt is forced low during reset so nothing is accepted then.
  assign gnt_o     = req_i & rst_n;
  assign word_idx  = addr_i[ADDR_WIDTH-1:BYTE_OFF];
  assign bank_full = word_idx >> IN_W;
  assign bank_sel  = bank_full[BANK_IDX_W-1:0];
  assign out_range = bank_full >= WORD_W'(NUM_BANKS);
  assign access    = req_i & gnt_o;
  assign read_ok   = access & ~we_i & ~out_range;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    boot_rom_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (IN_W),
      .BANK_ID    (b)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .cs_i   (read_ok && (bank_sel == BANK_IDX_W'(b))),
      .addr_i (word_idx[IN_W-1:0]),
      .csn_o  (bank_csn[b]),
      .q_o    (bank_q[b])
    );
  end

  always_comb begin
    resp0_d.valid = access;
    resp0_d.err   = access & ~read_ok;
    resp0_d.bank  = bank_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_q <= '0;
    end else begin
      resp0_q <= resp0_d;
    end
  end

  always_comb begin
    mux_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (resp0_q.bank == BANK_IDX_W'(b)) mux_data = bank_q[b];
    end
    s0_data = (resp0_q.valid && !resp0_q.err) ? mux_data : '0;
  end

  if (PIPE_STAGES == 0) begin : g_nopipe
    assign out_resp = resp0_q;
    assign out_data = s0_data;
  end else begin : g_pipe
    resp_t                 pipe_resp_q [PIPE_STAGES];
    logic [DATA_WIDTH-1:0] pipe_data_q [PIPE_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_STAGES; i++) begin
          pipe_resp_q[i] <= '0;
          pipe_data_q[i] <= '0;
        end
      end else begin
        pipe_resp_q[0] <= resp0_q;
        pipe_data_q[0] <= s0_data;
        for (int i = 1; i < PIPE_STAGES; i++) begin
          pipe_resp_q[i] <= pipe_resp_q[i-1];
          pipe_data_q[i] <= pipe_data_q[i-1];
        end
      end
    end

    assign out_resp = pipe_resp_q[PIPE_STAGES-1];
    assign out_data = pipe_data_q[PIPE_STAGES-1];
  end

  assign rvalid_o = out_resp.valid;
  assign err_o    = out_resp.valid & out_resp.err;
  assign rdata_o  = out_data;

`ifdef BOOT_ROM_PERF_CNT_EN
  logic [31:0] acc_cnt_d, acc_cnt_q;
  logic [15:0] err_cnt_d, err_cnt_q;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (rvalid_o && !err_o && acc_cnt_q != '1) acc_cnt_d = acc_cnt_q + 32'd1;
    if (err_o && err_cnt_q != '1)              err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign acc_cnt_o = acc_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule
